// File: rtl/ps2_lcd_bridge.sv
// PS/2 keyboard to HD44780-style character LCD bridge.
// Scan codes are edge-captured and filtered into a small FIFO. An FSM runs
// the LCD power-up/init sequence and then turns each queued key into LCD
// transactions, tracking a two-line cursor.
module ps2_lcd_bridge #(
    parameter int unsigned POWERUP_CYC = 1111111,
    parameter int unsigned EN_CYC      = 13,
    parameter int unsigned CMD_CYC     = 1112,
    parameter int unsigned CLR_CYC     = 45556,
    parameter int unsigned FIFO_DEPTH  = 8,
    parameter int unsigned COLS        = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       go,
    input  logic [7:0] ps2_code,
    input  logic       ps2_code_new,
    output logic [7:0] lcd_char,
    output logic       en,
    output logic       rs,
    output logic       ready,
    output logic       overflow
);

    localparam int unsigned AW    = $clog2(FIFO_DEPTH);
    localparam int unsigned COL_W = $clog2(COLS);

    localparam logic [AW:0]      FIFO_FULL = (AW + 1)'(FIFO_DEPTH);
    localparam logic [COL_W-1:0] COL_LAST  = COL_W'(COLS - 1);

    localparam logic [7:0] CMD_CLEAR = 8'h01;
    localparam logic [7:0] ASCII_BS  = 8'h08;
    localparam logic [7:0] ASCII_SP  = 8'h20;

    localparam logic [2:0] S_PWRUP   = 3'd0;
    localparam logic [2:0] S_INIT    = 3'd1;
    localparam logic [2:0] S_IDLE    = 3'd2;
    localparam logic [2:0] S_SETADDR = 3'd3;
    localparam logic [2:0] S_WRITE   = 3'd4;
    localparam logic [2:0] S_BKSP    = 3'd5;
    localparam logic [2:0] S_WAIT    = 3'd6;

    // Set-2 make code to uppercase ASCII; 0x08 marks backspace, 0x00 means
    // "not displayable" and the entry is simply discarded.
    function automatic logic [7:0] scan_to_ascii(input logic [7:0] code);
        logic [7:0] a;
        case (code)
            8'h1C: a = 8'h41;  8'h32: a = 8'h42;  8'h21: a = 8'h43;
            8'h23: a = 8'h44;  8'h24: a = 8'h45;  8'h2B: a = 8'h46;
            8'h34: a = 8'h47;  8'h33: a = 8'h48;  8'h43: a = 8'h49;
            8'h3B: a = 8'h4A;  8'h42: a = 8'h4B;  8'h4B: a = 8'h4C;
            8'h3A: a = 8'h4D;  8'h31: a = 8'h4E;  8'h44: a = 8'h4F;
            8'h4D: a = 8'h50;  8'h15: a = 8'h51;  8'h2D: a = 8'h52;
            8'h1B: a = 8'h53;  8'h2C: a = 8'h54;  8'h3C: a = 8'h55;
            8'h2A: a = 8'h56;  8'h1D: a = 8'h57;  8'h22: a = 8'h58;
            8'h35: a = 8'h59;  8'h1A: a = 8'h5A;
            8'h45: a = 8'h30;  8'h16: a = 8'h31;  8'h1E: a = 8'h32;
            8'h26: a = 8'h33;  8'h25: a = 8'h34;  8'h2E: a = 8'h35;
            8'h36: a = 8'h36;  8'h3D: a = 8'h37;  8'h3E: a = 8'h38;
            8'h46: a = 8'h39;
            8'h29: a = ASCII_SP;
            8'h66: a = ASCII_BS;
            default: a = 8'h00;
        endcase
        return a;
    endfunction

    // Set-DDRAM-address command for a cursor position.
    function automatic logic [7:0] ddram_addr(input logic ln, input logic [COL_W-1:0] c);
        return (ln ? 8'hC0 : 8'h80) | 8'(c);
    endfunction

    // Function set (8-bit, 2 lines), display on, clear, entry mode increment.
    function automatic logic [7:0] init_cmd(input logic [1:0] idx);
        logic [7:0] c;
        case (idx)
            2'd0:    c = 8'h38;
            2'd1:    c = 8'h0C;
            2'd2:    c = CMD_CLEAR;
            default: c = 8'h06;
        endcase
        return c;
    endfunction

    // FIFO and capture state
    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   fill;
    logic          new_q;
    logic          skip;
    logic          capture;
    logic          push_req;
    logic          push;
    logic          pop;
    logic          full;
    logic          empty;
    logic [7:0]    head_ascii;

    // Sequencer state
    logic [2:0]       state;
    logic [2:0]       ret_state;
    logic [2:0]       after_cmd;
    logic [31:0]      cnt;
    logic [31:0]      wait_last;
    logic [2:0]       init_idx;
    logic [7:0]       cur_char;
    logic [7:0]       cmd_reg;
    logic [1:0]       bk_step;
    logic             line;
    logic [COL_W-1:0] col;
    logic             clr_wait;

    // Capture qualification, FIFO flags and head decode
    always_comb begin
        capture    = ps2_code_new && !new_q && ready;
        push_req   = capture && !skip && (ps2_code != 8'hF0) && (ps2_code != 8'hE0);
        full       = (fill == FIFO_FULL);
        empty      = (fill == '0);
        pop        = (state == S_IDLE) && !empty;
        push       = push_req && (!full || pop);
        head_ascii = scan_to_ascii(mem[rd_ptr]);
        wait_last  = EN_CYC + (clr_wait ? CLR_CYC : CMD_CYC);
    end

    // Strobe edge detect, prefix filtering, FIFO pointers and overflow flag
    always_ff @(posedge clk) begin
        if (rst) begin
            new_q    <= 1'b0;
            skip     <= 1'b0;
            overflow <= 1'b0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fill     <= '0;
        end else begin
            new_q <= ps2_code_new;
            if (capture) begin
                if (skip)
                    skip <= 1'b0;
                else if ((ps2_code == 8'hF0) || (ps2_code == 8'hE0))
                    skip <= 1'b1;
            end
            if (push_req && full && !pop)
                overflow <= 1'b1;
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop)
                fill <= fill + 1'b1;
            else if (!push && pop)
                fill <= fill - 1'b1;
        end
    end

    // FIFO storage; contents need no reset since fill gates every read
    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= ps2_code;
    end

    // Main sequencer. Every issuing state loads the bus and hands off to
    // S_WAIT, which times en and the settle delay, then resumes at ret_state.
    // A clear after the last cell reuses S_SETADDR via cmd_reg/after_cmd.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_PWRUP;
            ret_state <= S_PWRUP;
            after_cmd <= S_PWRUP;
            cnt       <= '0;
            init_idx  <= '0;
            cur_char  <= '0;
            cmd_reg   <= '0;
            bk_step   <= '0;
            line      <= 1'b0;
            col       <= '0;
            clr_wait  <= 1'b0;
            lcd_char  <= '0;
            en        <= 1'b0;
            rs        <= 1'b0;
            ready     <= 1'b0;
        end else begin
            case (state)
                S_PWRUP: begin
                    if (!go) begin
                        cnt <= '0;
                    end else if (cnt == POWERUP_CYC - 1) begin
                        cnt   <= '0;
                        state <= S_INIT;
                    end else begin
                        cnt <= cnt + 32'd1;
                    end
                end

                S_INIT: begin
                    if (init_idx == 3'd4) begin
                        ready <= 1'b1;
                        state <= S_IDLE;
                    end else begin
                        lcd_char  <= init_cmd(init_idx[1:0]);
                        rs        <= 1'b0;
                        en        <= 1'b0;
                        cnt       <= '0;
                        clr_wait  <= (init_cmd(init_idx[1:0]) == CMD_CLEAR);
                        ret_state <= S_INIT;
                        state     <= S_WAIT;
                        init_idx  <= init_idx + 3'd1;
                    end
                end

                S_IDLE: begin
                    if (!empty) begin
                        if (head_ascii == ASCII_BS) begin
                            if (line || (col != '0)) begin
                                if (col != '0) begin
                                    col <= col - 1'b1;
                                end else begin
                                    line <= 1'b0;
                                    col  <= COL_LAST;
                                end
                                bk_step <= 2'd0;
                                state   <= S_BKSP;
                            end
                        end else if (head_ascii != 8'h00) begin
                            cur_char <= head_ascii;
                            if (col == '0) begin
                                cmd_reg   <= ddram_addr(line, col);
                                after_cmd <= S_WRITE;
                                state     <= S_SETADDR;
                            end else begin
                                state <= S_WRITE;
                            end
                        end
                    end
                end

                S_SETADDR: begin
                    lcd_char  <= cmd_reg;
                    rs        <= 1'b0;
                    en        <= 1'b0;
                    cnt       <= '0;
                    clr_wait  <= (cmd_reg == CMD_CLEAR);
                    ret_state <= after_cmd;
                    state     <= S_WAIT;
                end

                S_WRITE: begin
                    lcd_char <= cur_char;
                    rs       <= 1'b1;
                    en       <= 1'b0;
                    cnt      <= '0;
                    clr_wait <= 1'b0;
                    state    <= S_WAIT;
                    if (col != COL_LAST) begin
                        col       <= col + 1'b1;
                        ret_state <= S_IDLE;
                    end else if (!line) begin
                        line      <= 1'b1;
                        col       <= '0;
                        ret_state <= S_IDLE;
                    end else begin
                        line      <= 1'b0;
                        col       <= '0;
                        cmd_reg   <= CMD_CLEAR;
                        after_cmd <= S_IDLE;
                        ret_state <= S_SETADDR;
                    end
                end

                S_BKSP: begin
                    en       <= 1'b0;
                    cnt      <= '0;
                    clr_wait <= 1'b0;
                    state    <= S_WAIT;
                    case (bk_step)
                        2'd0: begin
                            lcd_char  <= ddram_addr(line, col);
                            rs        <= 1'b0;
                            ret_state <= S_BKSP;
                            bk_step   <= 2'd1;
                        end
                        2'd1: begin
                            lcd_char  <= ASCII_SP;
                            rs        <= 1'b1;
                            ret_state <= S_BKSP;
                            bk_step   <= 2'd2;
                        end
                        default: begin
                            lcd_char  <= ddram_addr(line, col);
                            rs        <= 1'b0;
                            ret_state <= S_IDLE;
                            bk_step   <= 2'd0;
                        end
                    endcase
                end

                S_WAIT: begin
                    if (cnt == wait_last) begin
                        cnt   <= '0;
                        en    <= 1'b0;
                        state <= ret_state;
                    end else begin
                        cnt <= cnt + 32'd1;
                        en  <= (cnt < EN_CYC);
                    end
                end

                default: state <= S_PWRUP;
            endcase
        end
    end

endmodule

// File: tb/tb_ps2_lcd_bridge.sv
// Directed bench for ps2_lcd_bridge: init sequence, key capture/filtering,
// cursor wrap and clear, FIFO overflow, backspace and mid-transaction reset.
module tb_ps2_lcd_bridge;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       go = 1'b0;
    logic [7:0] ps2_code = 8'h00;
    logic       ps2_code_new = 1'b0;
    logic [7:0] lcd_char;
    logic       en;
    logic       rs;
    logic       ready;
    logic       overflow;

    int checks = 0;
    int errors = 0;

    // Observed transactions as {rs, lcd_char}
    logic [8:0] txq[$];
    logic [8:0] exp_q[$];

    // Bus monitor state
    logic       en_q = 1'b0;
    logic       ready_q = 1'b0;
    logic [8:0] prev_bus = '0;
    logic [8:0] cur_bus = '0;
    int         hi_cnt = 0;
    int         low_cnt = 0;
    int         need = 10;
    bit         have_prev = 1'b0;
    bit         in_hi = 1'b0;
    bit         stable = 1'b1;

    ps2_lcd_bridge #(
        .POWERUP_CYC(100),
        .EN_CYC     (2),
        .CMD_CYC    (10),
        .CLR_CYC    (20),
        .FIFO_DEPTH (4),
        .COLS       (4)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .go          (go),
        .ps2_code    (ps2_code),
        .ps2_code_new(ps2_code_new),
        .lcd_char    (lcd_char),
        .en          (en),
        .rs          (rs),
        .ready       (ready),
        .overflow    (overflow)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL timeout got=running exp=finished");
        $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
        $fatal(1, "timeout");
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Compare the logged transactions against exp_q, then clear the log
    task automatic check_seq(input string tag);
        check_val({tag, "_len"}, txq.size(), exp_q.size());
        foreach (exp_q[i])
            if (i < txq.size())
                check_val(tag, txq[i], exp_q[i]);
        txq.delete();
    endtask

    // One-cycle strobe, then gap idle cycles
    task automatic key(input logic [7:0] c, input int gap);
        @(negedge clk);
        ps2_code     = c;
        ps2_code_new = 1'b1;
        @(negedge clk);
        ps2_code_new = 1'b0;
        repeat (gap) @(negedge clk);
    endtask

    task automatic wait_ready();
        int n = 0;
        while (!ready && n < 1000) begin
            @(negedge clk);
            n++;
        end
        check_val("ready", ready, 1);
    endtask

    task automatic reset_and_init();
        @(negedge clk);
        rst = 1'b1;
        go = 1'b0;
        ps2_code_new = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        go = 1'b1;
        wait_ready();
        repeat (5) @(negedge clk);
        txq.delete();
    endtask

    // Logs transactions and checks en width, setup, hold and settle time
    always @(negedge clk) begin
        if (rst) begin
            have_prev = 1'b0;
            in_hi     = 1'b0;
            low_cnt   = 0;
        end else if (en && !en_q) begin
            check_val("setup", {rs, lcd_char}, prev_bus);
            if (have_prev) begin
                check_val("cmd_wait", (low_cnt >= need + 1), 1);
                check_val("bus_hold", stable, 1);
            end
            cur_bus = {rs, lcd_char};
            txq.push_back(cur_bus);
            hi_cnt = 1;
            stable = 1'b1;
            in_hi  = 1'b1;
        end else if (en) begin
            hi_cnt++;
            if ({rs, lcd_char} != cur_bus) stable = 1'b0;
        end else begin
            if (en_q && in_hi) begin
                check_val("en_width", hi_cnt, 2);
                in_hi     = 1'b0;
                have_prev = 1'b1;
                need      = (cur_bus == 9'h001) ? 20 : 10;
                low_cnt   = 0;
            end
            low_cnt++;
            if (have_prev && low_cnt <= need && {rs, lcd_char} != cur_bus) stable = 1'b0;
        end
        if (!rst && ready && !ready_q)
            check_val("ready_late", (have_prev && low_cnt >= 10), 1);
        en_q     = en;
        ready_q  = ready;
        prev_bus = {rs, lcd_char};
    end

    initial begin
        int n;

        // Reset values
        repeat (3) @(negedge clk);
        check_val("rst_lcd_char", lcd_char, 8'h00);
        check_val("rst_en", en, 0);
        check_val("rst_rs", rs, 0);
        check_val("rst_ready", ready, 0);
        check_val("rst_overflow", overflow, 0);

        // go=0 holds in power-up; keys before ready are rejected
        rst = 1'b0;
        key(8'h1C, 10);
        repeat (200) @(negedge clk);
        check_val("go_hold_tx", txq.size(), 0);
        check_val("go_hold_ready", ready, 0);

        // Power-up delay and init sequence
        go = 1'b1;
        n = 0;
        while (!en && n < 1000) begin
            @(negedge clk);
            n++;
        end
        check_val("pwrup_delay", (n > 100) && (n < 120), 1);
        wait_ready();
        exp_q = {9'h038, 9'h00C, 9'h001, 9'h006};
        check_seq("init");

        // Held strobe gives exactly one capture
        repeat (5) @(negedge clk);
        ps2_code     = 8'h1C;
        ps2_code_new = 1'b1;
        repeat (500) @(negedge clk);
        ps2_code_new = 1'b0;
        repeat (100) @(negedge clk);
        exp_q = {9'h080, 9'h141};
        check_seq("held");

        // Break code filtering
        reset_and_init();
        key(8'h1C, 60);
        key(8'hF0, 60);
        key(8'h1C, 60);
        key(8'h32, 60);
        exp_q = {9'h080, 9'h141, 9'h142};
        check_seq("break");

        // Digits, space, unknown code, line-1 address, E0 prefix (cursor at 0,2)
        key(8'h45, 60);
        key(8'h76, 60);
        key(8'h29, 60);
        key(8'h46, 60);
        key(8'hE0, 60);
        key(8'h1C, 60);
        key(8'h32, 60);
        exp_q = {9'h130, 9'h120, 9'h0C0, 9'h139, 9'h142};
        check_seq("xlate");

        // Wrap across lines, clear at end of line 1, then cursor at (0,1)
        reset_and_init();
        repeat (9) key(8'h1C, 80);
        key(8'h32, 80);
        exp_q = {9'h080, 9'h141, 9'h141, 9'h141, 9'h141, 9'h0C0, 9'h141, 9'h141,
                 9'h141, 9'h141, 9'h001, 9'h080, 9'h141, 9'h142};
        check_seq("wrap");

        // Overflow: burst of six keys during the clear wait
        reset_and_init();
        repeat (7) key(8'h1C, 80);
        key(8'h1C, 0);
        n = 0;
        while (!(en && lcd_char == 8'h01 && !rs) && n < 400) begin
            @(negedge clk);
            n++;
        end
        check_val("clr_seen", (en && lcd_char == 8'h01 && !rs), 1);
        n = 0;
        while (en && n < 50) begin
            @(negedge clk);
            n++;
        end
        txq.delete();
        key(8'h1C, 0);
        key(8'h32, 0);
        key(8'h21, 0);
        key(8'h23, 0);
        key(8'h24, 0);
        key(8'h2B, 0);
        check_val("ovf_set", overflow, 1);
        repeat (400) @(negedge clk);
        exp_q = {9'h080, 9'h141, 9'h142, 9'h143, 9'h144};
        check_seq("ovf_chars");
        check_val("ovf_sticky", overflow, 1);
        rst = 1'b1;
        @(negedge clk);
        check_val("ovf_rst", overflow, 0);
        rst = 1'b0;

        // Backspace, backspace at home, backspace across the line boundary
        reset_and_init();
        key(8'h1C, 80);
        key(8'h66, 80);
        exp_q = {9'h080, 9'h141, 9'h080, 9'h120, 9'h080};
        check_seq("bksp");
        key(8'h66, 80);
        exp_q.delete();
        check_seq("bksp_home");
        repeat (4) key(8'h1C, 80);
        key(8'h66, 80);
        exp_q = {9'h080, 9'h141, 9'h141, 9'h141, 9'h141, 9'h083, 9'h120, 9'h083};
        check_seq("bksp_wrap");

        // Reset while en is high
        key(8'h1C, 0);
        n = 0;
        while (!en && n < 300) begin
            @(negedge clk);
            n++;
        end
        check_val("midop_en_seen", en, 1);
        rst = 1'b1;
        @(negedge clk);
        check_val("midop_en", en, 0);
        check_val("midop_lcd_char", lcd_char, 8'h00);
        check_val("midop_ready", ready, 0);
        check_val("midop_rs", rs, 0);
        rst = 1'b0;
        repeat (5) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ps2_lcd_bridge.md
PS2_LCD_BRIDGE -- requirements
Module: ps2_lcd_bridge

Interface
REQ-001 SHALL have parameter POWERUP_CYC, default 1111111, meaning clk cycles waited after go before the first LCD command (40 ms at 36 ns clk).
REQ-002 SHALL have parameter EN_CYC, default 13, meaning en high width in cycles.
REQ-003 SHALL have parameter CMD_CYC, default 1112, meaning wait after en falls for every command except clear.
REQ-004 SHALL have parameter CLR_CYC, default 45556, meaning wait after en falls for clear (0x01).
REQ-005 SHALL have parameter FIFO_DEPTH, default 8, meaning scan-code FIFO entries; power of 2, at least 2.
REQ-006 SHALL have parameter COLS, default 16, meaning characters per LCD line; range 2..40.
REQ-007 SHALL have port clk, input, 1, meaning the single clock; all logic on its rising edge.
REQ-008 SHALL have port rst, input, 1, meaning reset: synchronous, active-high.
REQ-009 SHALL have port go, input, 1, meaning start enable; the power-up counter runs only while go=1.
REQ-010 SHALL have port ps2_code, input, 8, meaning PS/2 scan code.
REQ-011 SHALL have port ps2_code_new, input, 1, meaning code valid; may be held high for any number of cycles.
REQ-012 SHALL have port lcd_char, output, 8, meaning LCD data bus D7..D0.
REQ-013 SHALL have port en, output, 1, meaning LCD enable strobe.
REQ-014 SHALL have port rs, output, 1, meaning LCD register select: 0 command, 1 data.
REQ-015 SHALL have port ready, output, 1, meaning init sequence complete.
REQ-016 SHALL have port overflow, output, 1, meaning sticky flag set when a code arrives with the FIFO full.

Function
REQ-017 SHALL capture ps2_code into the FIFO only on the cycle where ps2_code_new is 1 and its registered previous value is 0 (rising edge); a held level SHALL produce exactly one capture.
REQ-018 SHALL filter at capture time:
- 0xF0 sets a skip flag; the next code is discarded and the flag is cleared.
- 0xE0 sets the same skip flag.
- Discarded codes never enter the FIFO.
REQ-019 SHALL drop the code and set overflow when a capture occurs with the FIFO full; FIFO contents are unchanged.
REQ-020 SHALL write and read in the same cycle when a capture and a pop coincide with the FIFO full; this case is not an overflow.
REQ-021 SHALL translate scan codes using standard set-2 to uppercase ASCII:
- Letters 0x1C..0x1A ('A'..'Z').
- Digits 0x45,0x16..0x46 ('0'..'9').
- Space 0x29 -> 0x20.
- Backspace 0x66.
- Any other code SHALL be popped and ignored.
REQ-022 SHALL execute every LCD transaction as:
- Cycle 0: rs and lcd_char driven.
- Cycles 1..EN_CYC: en=1.
- Then en=0 for CMD_CYC cycles (CLR_CYC for 0x01).
- rs and lcd_char held stable throughout.
REQ-023 SHALL sequence the FSM as PWRUP -> INIT -> IDLE <-> (SETADDR, WRITE, BKSP) -> WAIT.
REQ-024 SHALL wait POWERUP_CYC cycles in PWRUP (go=1), then issue INIT commands 0x38, 0x0C, 0x01, 0x06 in order, then assert ready and enter IDLE.
REQ-025 SHALL maintain cursor state {line 0..1, col 0..COLS-1}, which is (0,0) after init.
REQ-026 SHALL, in IDLE with the FIFO non-empty, pop one entry per character transaction.
REQ-027 SHALL handle printable characters as:
- If col=0, first issue set-address 0x80 (line 0) or 0xC0 (line 1).
- Then write data (rs=1).
- Then increment col.
REQ-028 SHALL wrap col COLS-1 on line 0 to line 1, col 0.
REQ-029 SHALL handle col COLS-1 on line 1 as: issue clear 0x01, then cursor (0,0).
REQ-030 SHALL handle backspace as:
- At (0,0): ignored, nothing issued.
- Otherwise compute the previous position (line 1 col 0 -> line 0 col COLS-1).
- Issue set-address(prev), write 0x20, set-address(prev).
- Cursor becomes prev.
REQ-031 SHALL reject captures (no FIFO write) while ready=0.

Reset
REQ-032 SHALL, on rst=1 at a rising edge, set next cycle: lcd_char=0x00, en=0, rs=0, ready=0, overflow=0, FIFO empty, skip flag clear, cursor (0,0), state PWRUP, counters 0.
REQ-033 SHALL abort any transaction in progress on a mid-operation reset, with en forced to 0 that cycle.
REQ-034 SHALL have go=0 hold the block in PWRUP with the counter at 0.

Verification
Bench parameters: POWERUP_CYC=100, EN_CYC=2, CMD_CYC=10, CLR_CYC=20, FIFO_DEPTH=4, COLS=4.
REQ-035 SHALL cover init: go=1 after reset -> after 100 cycles, commands 0x38, 0x0C, 0x01, 0x06 with rs=0, each with en high 2 cycles; ready=1 after the final wait.
REQ-036 SHALL cover a held strobe: ps2_code=0x1C, ps2_code_new held high 500 cycles -> exactly set-address 0x80, then data 0x41 rs=1; no second 'A'.
REQ-037 SHALL cover break codes: sequence 0x1C, 0xF0, 0x1C, 0x32 -> data 'A', 'B' only.
REQ-038 SHALL cover wrap: 9 'A' keys -> 0x80, AAAA, 0xC0, AAAA, 0x01 (20-cycle wait), 0x80, A; final cursor (0,1).
REQ-039 SHALL cover overflow: 6 strobes spaced 2 cycles during a CLR wait -> 4 characters written, overflow=1, cleared only by rst.
REQ-040 SHALL cover backspace and mid-op reset: 'A', backspace -> 0x80, 0x41, 0x80, 0x20, 0x80; rst asserted while en=1 -> en=0, lcd_char=0x00, ready=0 next cycle.
